// File: rtl/lru_evict_drain.sv
// Writeback drain for LRU victims: dirty entries go into a small FIFO and leave over wb_*, while clean entries are dropped and counted.
// Optional build macro LRU_EVICT_MERGE_EN merges a dirty victim into a matching non-head entry in place.
module lru_evict_drain #(
  parameter int DATAW      = 64,
  parameter int DEPTH      = 4,
  parameter int LINE_ADDRW = 26,
  parameter int CNTW       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         evict_valid,
  input  logic                         evict_dirty,
  input  logic [DATAW-1:0]             evict_data,
  output logic                         evict_ready,
  output logic                         wb_valid,
  output logic [DATAW-1:0]             wb_data,
  input  logic                         wb_ready,
  input  logic [LINE_ADDRW-1:0]        lookup_addr,
  output logic                         lookup_hit,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [CNTW-1:0]              drop_count
);
  localparam int PTRW  = $clog2(DEPTH);
  localparam int PENDW = $clog2(DEPTH+1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  head_reg, tail_reg;
  logic [PENDW-1:0] pending_reg, pending_next;
  logic [CNTW-1:0]  drop_reg;
  logic [DEPTH-1:0] entry_valid, lookup_match, write_en;
  logic             full, fire, push, pop, merge;

  assign full = (pending_reg == PENDW'(DEPTH));
  assign fire = evict_valid && evict_ready;
  assign pop  = wb_valid && wb_ready;

`ifdef LRU_EVICT_MERGE_EN
  logic [DEPTH-1:0] evict_match;
  logic             match_nonhead;
  assign match_nonhead = |evict_match;
  assign evict_ready   = !full || match_nonhead;
  assign merge         = fire && evict_dirty && match_nonhead;
`else
  assign evict_ready = !full;
  assign merge       = 1'b0;
`endif
  assign push = fire && evict_dirty && !merge;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTRW-1:0] offs;
    assign offs             = PTRW'(gi) - head_reg;
    assign entry_valid[gi]  = PENDW'(offs) < pending_reg;
    assign lookup_match[gi] = entry_valid[gi] &&
                              (mem[gi][DATAW-2 -: LINE_ADDRW] == lookup_addr);
`ifdef LRU_EVICT_MERGE_EN
    // The head is excluded because it may already be on its way to memory.
    assign evict_match[gi] = entry_valid[gi] && (PTRW'(gi) != head_reg) &&
                             (mem[gi][DATAW-2 -: LINE_ADDRW] == evict_data[DATAW-2 -: LINE_ADDRW]);
    assign write_en[gi]    = (push && (tail_reg == PTRW'(gi))) || (merge && evict_match[gi]);
`else
    assign write_en[gi]    = push && (tail_reg == PTRW'(gi));
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (write_en[i]) mem[i] <= evict_data;
    end
  end

  always_comb begin
    pending_next = pending_reg;
    case ({push, pop})
      2'b10:   pending_next = pending_reg + 1'b1;
      2'b01:   pending_next = pending_reg - 1'b1;
      default: pending_next = pending_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      pending_reg <= '0;
      drop_reg    <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      pending_reg <= pending_next;
      if (fire && !evict_dirty && (drop_reg != '1)) drop_reg <= drop_reg + 1'b1;
    end
  end

  assign wb_valid   = (pending_reg != '0);
  assign wb_data    = mem[head_reg];
  assign lookup_hit = |lookup_match;
  assign pending    = pending_reg;
  assign drop_count = drop_reg;

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

// File: tb/tb_lru_evict_drain.sv
// Scoreboard bench for lru_evict_drain: accepted dirty victims are queued, and each writeback is checked against the queue head.
module tb_lru_evict_drain;
  logic        clk, reset;
  logic        evict_valid, evict_dirty, evict_ready;
  logic [63:0] evict_data, wb_data;
  logic        wb_valid, wb_ready;
  logic [25:0] lookup_addr;
  logic        lookup_hit;
  logic [2:0]  pending;
  logic [15:0] drop_count;

  int tests = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  lru_evict_drain dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_dirty(evict_dirty), .evict_data(evict_data),
    .evict_ready(evict_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .pending(pending), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [25:0] addr, input logic [36:0] tag);
    return {1'b0, addr, tag};
  endfunction

  function automatic logic [25:0] line_of(input logic [63:0] d);
    return d[62:37];
  endfunction

  // Scoreboard: record accepted dirty victims, then check each writeback.
  always @(negedge clk) begin
    if (!reset) begin
      if (evict_valid && evict_ready && evict_dirty) begin
        bit merged;
        merged = 1'b0;
`ifdef LRU_EVICT_MERGE_EN
        for (int k = 1; k < exp_q.size(); k++) begin
          if (line_of(exp_q[k]) == line_of(evict_data)) begin
            exp_q[k] = evict_data;
            merged = 1'b1;
          end
        end
`endif
        if (!merged) exp_q.push_back(evict_data);
      end
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
        else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("wb_data", wb_data, e);
          $display("[TB] writeback %h", wb_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic dirty);
    int n;
    evict_valid = 1'b1;
    evict_data  = d;
    evict_dirty = dirty;
    n = 0;
    @(negedge clk);
    while (!evict_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("push_timeout", 64'd0, 64'd1);
    step();
    evict_valid = 1'b0;
    $display("[TB] evict %h dirty=%0d", d, dirty);
  endtask

  task automatic drain();
    int n;
    wb_ready = 1'b1;
    n = 0;
    while (pending != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_done", {61'd0, pending}, 64'd0);
    wb_ready = 1'b0;
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; evict_valid = 1'b0; evict_dirty = 1'b0; evict_data = '0;
    wb_ready = 1'b0; lookup_addr = '0;
    do_reset();

    @(negedge clk);
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_pending", {61'd0, pending}, 64'd0);
    check("rst_ready", {63'd0, evict_ready}, 64'd1);
    check("rst_hit", {63'd0, lookup_hit}, 64'd0);
    check("rst_drops", {48'd0, drop_count}, 64'd0);
    step();

    // A: not visible while entering, visible the cycle after.
    lookup_addr = 26'h10;
    evict_valid = 1'b1; evict_dirty = 1'b1; evict_data = mk(26'h10, 37'h1);
    @(negedge clk);
    check("hit_entering", {63'd0, lookup_hit}, 64'd0);
    check("wb_valid_same", {63'd0, wb_valid}, 64'd0);
    step();
    evict_valid = 1'b0;
    check("hit_next", {63'd0, lookup_hit}, 64'd1);
    check("wb_valid_next", {63'd0, wb_valid}, 64'd1);
    push(mk(26'h20, 37'h2), 1'b1);
    push(mk(26'h30, 37'h3), 1'b1);
    @(negedge clk);
    check("pending3", {61'd0, pending}, 64'd3);
    check("head_is_a", wb_data, mk(26'h10, 37'h1));
    lookup_addr = 26'h20; #1;
    check("hit_b", {63'd0, lookup_hit}, 64'd1);
    lookup_addr = 26'h40; #1;
    check("miss_40", {63'd0, lookup_hit}, 64'd0);

    // Fill, hold a 5th, then free one slot.
    step();
    push(mk(26'h50, 37'h4), 1'b1);
    evict_valid = 1'b1; evict_dirty = 1'b1; evict_data = mk(26'h60, 37'h5);
    @(negedge clk);
    check("full_ready", {63'd0, evict_ready}, 64'd0);
    step(); step();
    check("full_pending", {61'd0, pending}, 64'd4);
    lookup_addr = 26'h10;
    wb_ready = 1'b1;
    @(negedge clk);
    check("hit_leaving", {63'd0, lookup_hit}, 64'd1);
    step();
    wb_ready = 1'b0;
    @(negedge clk);
    check("ready_after_pop", {63'd0, evict_ready}, 64'd1);
    check("pending_after_pop", {61'd0, pending}, 64'd3);
    step();
    evict_valid = 1'b0;
    check("pending_refill", {61'd0, pending}, 64'd4);
    drain();

    // Clean victims interleaved with dirty ones.
    push(mk(26'h70, 37'h6), 1'b0);
    push(mk(26'h71, 37'h7), 1'b1);
    push(mk(26'h72, 37'h8), 1'b0);
    push(mk(26'h73, 37'h9), 1'b0);
    push(mk(26'h74, 37'ha), 1'b1);
    push(mk(26'h75, 37'hb), 1'b0);
    push(mk(26'h76, 37'hc), 1'b0);
    check("drops5", {48'd0, drop_count}, 64'd5);
    check("pending2", {61'd0, pending}, 64'd2);
    drain();

    // Steady state: one in, one out each cycle.
    push(mk(26'h100, 37'h100), 1'b1);
    wb_ready = 1'b1; evict_valid = 1'b1; evict_dirty = 1'b1;
    for (int i = 0; i < 20; i++) begin
      evict_data = mk(26'h101 + 26'(i), 37'h200 + 37'(i));
      @(negedge clk);
      check("steady_pending", {61'd0, pending}, 64'd1);
      step();
    end
    evict_valid = 1'b0;
    drain();

    // Reset in the middle of a drain.
    push(mk(26'h80, 37'hd), 1'b1);
    push(mk(26'h81, 37'he), 1'b1);
    push(mk(26'h82, 37'hf), 1'b1);
    reset = 1'b1; wb_ready = 1'b1;
    step();
    exp_q.delete();
    reset = 1'b0; wb_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("mid_rst_pending", {61'd0, pending}, 64'd0);
    check("mid_rst_drops", {48'd0, drop_count}, 64'd0);
    check("mid_rst_ready", {63'd0, evict_ready}, 64'd1);
    step();

    // Same-address victims: merge into a non-head entry, never into the head.
    push(mk(26'h10, 37'h11), 1'b1);
    push(mk(26'h20, 37'h12), 1'b1);
    push(mk(26'h20, 37'h13), 1'b1);
`ifdef LRU_EVICT_MERGE_EN
    check("merge_pending", {61'd0, pending}, 64'd2);
    push(mk(26'h10, 37'h14), 1'b1);
    check("head_match_pending", {61'd0, pending}, 64'd3);
`else
    check("dup_pending", {61'd0, pending}, 64'd3);
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
